// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default bit timing.
package uart_pkg;

  typedef logic [2:0] rx_state_t;

  localparam rx_state_t RxIdle  = 3'd0;
  localparam rx_state_t RxStart = 3'd1;
  localparam rx_state_t RxData  = 3'd2;
  localparam rx_state_t RxStop  = 3'd3;
  localparam rx_state_t RxBreak = 3'd4;

  // 100 MHz system clock, 115200 baud
  localparam int unsigned DefaultClksPerBit = 868;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input; resets to ResetVal.
module uart_sync2 #(
  parameter bit ResetVal = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, valid/ready byte delivery,
// framing-error and overrun pulses, line-break lockout.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = $clog2(DATA_BITS);
  localparam logic [CntW-1:0] CntMax  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);

  logic rx_s;

  uart_sync2 #(
    .ResetVal(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rx_s)
  );

  rx_state_t            state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 fe_q, fe_d;
  logic                 ov_q, ov_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = valid_q;
    fe_d    = 1'b0;
    ov_d    = 1'b0;

    // Consumer handshake; a delivery on the same cycle overrides this below.
    if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      RxIdle: begin
        if (!rx_s) begin
          state_d = RxStart;
          cnt_d   = '0;
        end
      end
      RxStart: begin
        if (cnt_q == CntHalf) begin
          if (rx_s) begin
            state_d = RxIdle;
          end else begin
            state_d = RxData;
            cnt_d   = '0;
            idx_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RxData: begin
        if (cnt_q == CntMax) begin
          cnt_d   = '0;
          shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
          if (idx_q == IdxLast) begin
            state_d = RxStop;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RxStop: begin
        if (cnt_q == CntMax) begin
          cnt_d = '0;
          if (rx_s) begin
            // Leave at mid-stop so a back-to-back start edge is not missed.
            state_d = RxIdle;
            if (!valid_q || data_ready) begin
              data_d  = shreg_q;
              valid_d = 1'b1;
            end else begin
              ov_d = 1'b1;
            end
          end else begin
            fe_d    = 1'b1;
            state_d = RxBreak;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RxBreak: begin
        if (rx_s) begin
          state_d = RxIdle;
        end
      end
      default: state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RxIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  assign data       = data_q;
  assign data_valid = valid_q;
  assign frame_err  = fe_q;
  assign overrun    = ov_q;
  assign busy       = (state_q != RxIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial driver, byte-queue reference model,
// vector table plus hand sequences for glitch, overrun, back-to-back and reset.
module tb_uart_rx;

  localparam int unsigned Cpb = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       data_ready;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  always #5 clk = ~clk;

  uart_rx #(
    .CLKS_PER_BIT(Cpb),
    .DATA_BITS   (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;

  // Monitor: bytes taken by the consumer and flag activity, sampled mid-cycle.
  logic [7:0] got[$];
  int n_valid = 0;
  int n_fe    = 0;
  int n_ov    = 0;
  int n_both  = 0;

  always @(negedge clk) begin
    if (data_valid && data_ready) got.push_back(data);
    if (data_valid) n_valid <= n_valid + 1;
    if (frame_err) n_fe <= n_fe + 1;
    if (overrun) n_ov <= n_ov + 1;
    if (frame_err && overrun) n_both <= n_both + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Serial driver: start, 8 data bits LSB-first, stop. A bad stop holds the
  // line low for low_bits bit times before releasing it.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int low_bits);
    rx = 1'b0;
    tick(Cpb);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(Cpb);
    end
    if (stop_ok) begin
      rx = 1'b1;
      tick(Cpb);
    end else begin
      rx = 1'b0;
      tick(low_bits * Cpb);
      rx = 1'b1;
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 1000) begin
      tick(1);
      n++;
    end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  typedef struct {
    logic [7:0] d;
    bit         stop_ok;
    int         low_bits;
    int         exp_bytes;
    int         exp_fe;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] exp_q[$];
  int         b_got, b_fe, b_ov, b_val;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{d: 8'hA5, stop_ok: 1'b1, low_bits: 0, exp_bytes: 1, exp_fe: 0};
    vecs[1] = '{d: 8'h3C, stop_ok: 1'b0, low_bits: 3, exp_bytes: 0, exp_fe: 1};
    vecs[2] = '{d: 8'h7E, stop_ok: 1'b1, low_bits: 0, exp_bytes: 1, exp_fe: 0};
    vecs[3] = '{d: 8'h81, stop_ok: 1'b1, low_bits: 0, exp_bytes: 1, exp_fe: 0};
    vecs[4] = '{d: 8'hFF, stop_ok: 1'b0, low_bits: 1, exp_bytes: 0, exp_fe: 1};
    vecs[5] = '{d: 8'h01, stop_ok: 1'b1, low_bits: 0, exp_bytes: 1, exp_fe: 0};

    rst        = 1'b1;
    rx         = 1'b1;
    data_ready = 1'b1;
    tick(3);
    check("reset_data", {24'd0, data}, 32'd0);
    check("reset_valid", {31'd0, data_valid}, 32'd0);
    check("reset_fe", {31'd0, frame_err}, 32'd0);
    check("reset_ov", {31'd0, overrun}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    tick(5);

    // Vector table, consumer always ready.
    for (int v = 0; v < 6; v++) begin
      b_got = got.size(); b_fe = n_fe; b_ov = n_ov; b_val = n_valid;
      send_frame(vecs[v].d, vecs[v].stop_ok, vecs[v].low_bits);
      wait_idle("vec_idle");
      tick(20);
      check("vec_bytes", got.size() - b_got, vecs[v].exp_bytes);
      if (got.size() > b_got) check("vec_data", {24'd0, got[b_got]}, {24'd0, vecs[v].d});
      check("vec_fe", n_fe - b_fe, vecs[v].exp_fe);
      check("vec_ov", n_ov - b_ov, 0);
      check("vec_valid_cycles", n_valid - b_val, vecs[v].exp_bytes);
      check("vec_valid_low", {31'd0, data_valid}, 32'd0);
    end

    // Short low glitch is rejected at the start-bit sample.
    b_got = got.size(); b_fe = n_fe; b_ov = n_ov;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    check("glitch_busy_seen", {31'd0, busy}, 32'd1);
    for (int n = 0; n < 10 && busy; n++) tick(1);
    check("glitch_busy_drop", {31'd0, busy}, 32'd0);
    tick(20);
    check("glitch_bytes", got.size() - b_got, 0);
    check("glitch_flags", (n_fe - b_fe) + (n_ov - b_ov), 0);

    // Overrun: second byte arrives while the first is still pending.
    data_ready = 1'b0;
    b_got = got.size(); b_fe = n_fe; b_ov = n_ov;
    send_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 0);
    tick(4);
    check("ovr_data_held", {24'd0, data}, 32'h11);
    check("ovr_valid_held", {31'd0, data_valid}, 32'd1);
    check("ovr_pulse", n_ov - b_ov, 1);
    check("ovr_no_fe", n_fe - b_fe, 0);
    data_ready = 1'b1;
    tick(1);
    data_ready = 1'b0;
    tick(2);
    check("ovr_valid_drop", {31'd0, data_valid}, 32'd0);
    tick(40);
    check("ovr_bytes", got.size() - b_got, 1);
    if (got.size() > b_got) check("ovr_first", {24'd0, got[b_got]}, 32'h11);
    data_ready = 1'b1;

    // Back-to-back frames with no idle gap.
    b_got = got.size(); b_fe = n_fe; b_ov = n_ov;
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    tick(4);
    check("b2b_bytes", got.size() - b_got, 2);
    if (got.size() >= b_got + 2) begin
      check("b2b_first", {24'd0, got[b_got]}, 32'h00);
      check("b2b_second", {24'd0, got[b_got+1]}, 32'hFF);
    end
    check("b2b_flags", (n_fe - b_fe) + (n_ov - b_ov), 0);

    // Reset in the middle of bit 4 of 0xC3.
    b_got = got.size(); b_fe = n_fe; b_ov = n_ov;
    begin
      logic [7:0] c3;
      c3 = 8'hC3;
      rx = 1'b0;
      tick(Cpb);
      for (int i = 0; i < 4; i++) begin
        rx = c3[i];
        tick(Cpb);
      end
      rx = c3[4];
      tick(Cpb / 2);
    end
    check("rst_busy_before", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_data", {24'd0, data}, 32'd0);
    check("rst_valid", {31'd0, data_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_flags", {30'd0, frame_err, overrun}, 32'd0);
    rx = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(3 * Cpb);
    check("rst_nothing", got.size() - b_got, 0);
    check("rst_no_flags", (n_fe - b_fe) + (n_ov - b_ov), 0);
    send_frame(8'h5A, 1'b1, 0);
    tick(4);
    check("rst_next_bytes", got.size() - b_got, 1);
    if (got.size() > b_got) check("rst_next_data", {24'd0, got[b_got]}, 32'h5A);

    // Random bytes with short random gaps against a byte-queue model.
    b_got = got.size(); b_fe = n_fe; b_ov = n_ov;
    for (int k = 0; k < 24; k++) begin
      logic [7:0] r;
      r = 8'($urandom);
      exp_q.push_back(r);
      send_frame(r, 1'b1, 0);
      rx = 1'b1;
      tick(int'($urandom_range(0, 3)));
    end
    wait_idle("rand_idle");
    tick(20);
    check("rand_count", got.size() - b_got, exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      if (b_got + k < got.size()) check("rand_data", {24'd0, got[b_got+k]}, {24'd0, exp_q[k]});
    end
    check("rand_flags", (n_fe - b_fe) + (n_ov - b_ov), 0);

    check("fe_ov_together", n_both, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
